// File: rtl/fetch_pkg.sv
// fetch_pkg: shared bus, entry types and reset defaults for the fetch front end
package fetch_pkg;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'hbfc0_0000;
    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
    } ibus_req_t;
    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: instruction bus, redirect and decode handshake of the fetch queue
interface fetch_queue_if;
    import fetch_pkg::*;
    ibus_req_t   ireq;
    ibus_resp_t  iresp;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    modport master (
        output ireq, out_valid, out_pc, out_instr,
        input  iresp, out_ready, redirect_valid, redirect_pc
    );
    modport slave (
        input  ireq, out_valid, out_pc, out_instr,
        output iresp, out_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: registered FIFO of fetched {pc, instr} entries; flush beats push and pop
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       i_push,
    input  fetch_entry_t               i_data,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output fetch_entry_t               o_head,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_full,
    output logic                       o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_wr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;
    assign w_push  = i_push & ~i_flush & ~o_full;
    assign w_pop   = i_pop & ~i_flush & ~o_empty;
    assign o_head  = r_mem[r_rd];
    assign o_count = r_count;
    assign o_full  = r_count == CW'(DEPTH);
    assign o_empty = r_count == '0;
    // pointers and occupancy; power-of-two depth lets the pointers wrap on their own
    always_ff @(posedge clk) begin
        if (!resetn || i_flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop) r_rd <= r_rd + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end
    // entry storage; occupancy alone decides what is visible, so no reset
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: sequential fetch issue, in-flight/discard accounting and redirect flush
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter int          MAX_OUT  = 2,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input logic           clk,
    input logic           resetn,
    fetch_queue_if.master bus
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int OW = $clog2(MAX_OUT+1);
    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_resp_pc;
    logic [31:0]   r_hold_addr;
    logic [OW-1:0] r_out;
    logic [OW-1:0] r_disc;
    logic          r_hold;
    logic          r_stale;
    logic [CW-1:0] w_count;
    logic          w_full;
    logic          w_empty;
    logic          w_issue;
    logic          w_acc;
    logic          w_resp;
    logic          w_push;
    logic          w_pop;
    logic [OW-1:0] w_out_next;
    fetch_entry_t  w_head;
    fetch_entry_t  w_entry;
    // credit rule: outstanding requests plus buffered entries never exceed the FIFO depth
    assign w_issue    = r_hold | (int'(r_out) < MAX_OUT && int'(w_count) + int'(r_out) < DEPTH);
    assign bus.ireq   = '{valid: resetn & w_issue, addr: r_hold ? r_hold_addr : r_fetch_pc};
    assign w_acc      = bus.ireq.valid & bus.iresp.addr_ok;
    assign w_resp     = bus.iresp.data_ok;
    assign w_push     = w_resp & ~bus.redirect_valid & (r_disc == '0) & ~w_full;
    assign w_pop      = bus.out_valid & bus.out_ready;
    assign w_out_next = r_out + OW'(w_acc) - OW'(w_resp);
    assign w_entry    = '{pc: r_resp_pc, instr: bus.iresp.data};
    assign bus.out_valid = resetn & ~w_empty;
    assign bus.out_pc    = resetn ? w_head.pc : '0;
    assign bus.out_instr = resetn ? w_head.instr : '0;
    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .i_push  (w_push),
        .i_data  (w_entry),
        .i_pop   (w_pop),
        .i_flush (bus.redirect_valid),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );
    // pcs and in-flight accounting; a held request keeps its address across a redirect
    // and, once stale, is counted as a discard when it is finally accepted
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_fetch_pc  <= RESET_PC;
            r_resp_pc   <= RESET_PC;
            r_hold_addr <= '0;
            r_out       <= '0;
            r_disc      <= '0;
            r_hold      <= 1'b0;
            r_stale     <= 1'b0;
        end else begin
            r_out       <= w_out_next;
            r_hold      <= bus.ireq.valid & ~bus.iresp.addr_ok;
            r_hold_addr <= bus.ireq.addr;
            if (bus.redirect_valid) begin
                r_fetch_pc <= bus.redirect_pc;
                r_resp_pc  <= bus.redirect_pc;
                r_disc     <= w_out_next;
                r_stale    <= bus.ireq.valid & ~bus.iresp.addr_ok;
            end else begin
                if (w_acc & ~r_stale) r_fetch_pc <= r_fetch_pc + 32'd4;
                if (w_push) r_resp_pc <= r_resp_pc + 32'd4;
                r_disc  <= r_disc - OW'(w_resp & (r_disc != '0)) + OW'(w_acc & r_stale);
                r_stale <= r_stale & ~w_acc;
            end
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed and random stimulus against a stream-level model of fetch_queue
module tb_fetch_queue;
    import fetch_pkg::*;
    localparam int          DEPTH   = 4;
    localparam int          MAX_OUT = 2;
    localparam logic [31:0] RPC     = 32'hbfc0_0000;
    typedef struct {
        logic [31:0] addr;
        int          ep;
        int          rdy;
    } bus_txn_t;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    fetch_queue_if bus_if();
    fetch_queue dut (.clk(clk), .resetn(resetn), .bus(bus_if));
    always #5 clk = ~clk;
    int          checks = 0;
    int          failures = 0;
    bus_txn_t    bus_q[$];
    int          cyc, cur_ep, held_ep, exp_cnt;
    logic [31:0] exp_pc, exp_issue, prev_addr;
    logic        prev_hold, prev_redir;
    int          aok_p, dok_p, rdy_p, lat_max, redir_p;
    logic        redir_v;
    logic [31:0] redir_pc;
    logic        s_v, s_ov, s_dok, s_pop;
    logic [31:0] s_addr, s_pc;

    function automatic logic [31:0] mem(logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5ee1_c0de;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        bus_q.delete();
        exp_pc = RPC;
        exp_issue = RPC;
        exp_cnt = 0;
        prev_hold = 1'b0;
        prev_redir = 1'b0;
        cur_ep = 0;
        held_ep = 0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        bus_if.iresp = '0;
        bus_if.out_ready = 1'b0;
        bus_if.redirect_valid = 1'b0;
        bus_if.redirect_pc = '0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("rst_ireq_valid", 32'(bus_if.ireq.valid), 32'd0);
            chk("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
            chk("rst_out_pc", bus_if.out_pc, 32'd0);
            chk("rst_out_instr", bus_if.out_instr, 32'd0);
            @(posedge clk); #1;
        end
        resetn = 1'b1;
        model_reset();
    endtask

    task automatic tick();
        logic        v, aok, dok, ordy, rv, acc, push;
        logic [31:0] addr;
        int          req_ep;
        bus_txn_t    t;
        aok  = $urandom_range(99) < aok_p;
        dok  = bus_q.size() > 0 && bus_q[0].rdy <= cyc && $urandom_range(99) < dok_p;
        ordy = $urandom_range(99) < rdy_p;
        rv   = redir_v || ($urandom_range(999) < redir_p);
        bus_if.redirect_pc = redir_v ? redir_pc : ($urandom & 32'hffff_fffc);
        bus_if.iresp.addr_ok = aok;
        bus_if.iresp.data_ok = dok;
        if (dok) bus_if.iresp.data = mem(bus_q[0].addr);
        else bus_if.iresp.data = $urandom;
        bus_if.out_ready = ordy;
        bus_if.redirect_valid = rv;
        redir_v = 1'b0;
        #1;
        v = bus_if.ireq.valid;
        addr = bus_if.ireq.addr;
        s_v = v;
        s_addr = addr;
        s_ov = bus_if.out_valid;
        s_pc = bus_if.out_pc;
        s_dok = dok;
        s_pop = s_ov & ordy & ~rv;
        if (prev_hold) begin
            chk("hold_valid", 32'(v), 32'd1);
            chk("hold_addr", addr, prev_addr);
        end
        if (prev_redir) chk("redirect_flush", 32'(s_ov), 32'd0);
        chk("out_valid", 32'(s_ov), 32'(exp_cnt > 0));
        if (exp_cnt == DEPTH) chk("full_no_issue", 32'(v), 32'd0);
        if (s_pop) begin
            chk("out_pc", s_pc, exp_pc);
            chk("out_instr", bus_if.out_instr, mem(exp_pc));
            exp_pc += 32'd4;
        end
        acc = v & aok;
        req_ep = prev_hold ? held_ep : cur_ep;
        if (acc) begin
            chk("max_outstanding", 32'(bus_q.size() < MAX_OUT), 32'd1);
            if (req_ep == cur_ep) begin
                chk("issue_addr", addr, exp_issue);
                exp_issue += 32'd4;
            end
            t.addr = addr;
            t.ep = req_ep;
            t.rdy = cyc + 1 + int'($urandom_range(lat_max));
            bus_q.push_back(t);
        end
        push = 1'b0;
        if (dok) begin
            t = bus_q.pop_front();
            push = (t.ep == cur_ep) && !rv;
        end
        exp_cnt = rv ? 0 : exp_cnt + int'(push) - int'(s_pop);
        if (push) chk("fifo_bound", 32'(exp_cnt <= DEPTH), 32'd1);
        if (rv) begin
            cur_ep++;
            exp_pc = bus_if.redirect_pc;
            exp_issue = bus_if.redirect_pc;
        end
        prev_hold = v & ~aok;
        held_ep = req_ep;
        prev_addr = addr;
        prev_redir = rv;
        @(posedge clk); #1;
        cyc++;
    endtask

    initial begin
        int found;
        int pops;
        aok_p = 100; dok_p = 100; rdy_p = 100; lat_max = 0; redir_p = 0;
        redir_v = 1'b0; redir_pc = '0; cyc = 0;
        bus_if.iresp = '0;
        bus_if.out_ready = 1'b0;
        bus_if.redirect_valid = 1'b0;
        bus_if.redirect_pc = '0;
        model_reset();
        @(posedge clk); #1;
        do_reset();
        // zero-wait bus: first entry after a two-cycle fill, then one per cycle
        tick();
        chk("first_valid", 32'(s_v), 32'd1);
        chk("first_addr", s_addr, RPC);
        tick();
        chk("fill_empty", 32'(s_ov), 32'd0);
        tick();
        chk("fill_valid", 32'(s_ov), 32'd1);
        chk("fill_pc0", s_pc, 32'hbfc0_0000);
        tick();
        chk("fill_pc1", s_pc, 32'hbfc0_0004);
        tick();
        chk("fill_pc2", s_pc, 32'hbfc0_0008);
        // decode stalled: FIFO fills to DEPTH and issue stops
        rdy_p = 0;
        repeat (8) tick();
        chk("full_ireq_valid", 32'(s_v), 32'd0);
        chk("full_out_valid", 32'(s_ov), 32'd1);
        rdy_p = 100;
        repeat (8) tick();
        // two requests in flight, redirect drops both responses
        dok_p = 0;
        for (int i = 0; i < 10 && bus_q.size() < 2; i++) tick();
        chk("two_outstanding", 32'(bus_q.size()), 32'd2);
        redir_v = 1'b1; redir_pc = 32'h8000_1000;
        tick();
        dok_p = 100;
        found = 0;
        for (int i = 0; i < 10 && found == 0; i++) begin
            tick();
            if (s_ov) found = 1;
        end
        chk("redirect_seen", 32'(found), 32'd1);
        chk("redirect_first_pc", s_pc, 32'h8000_1000);
        // held request across a redirect
        do_reset();
        tick();
        aok_p = 0;
        tick();
        chk("held_valid", 32'(s_v), 32'd1);
        chk("held_addr1", s_addr, 32'hbfc0_0004);
        redir_v = 1'b1; redir_pc = 32'h8000_2000;
        tick();
        chk("held_addr2", s_addr, 32'hbfc0_0004);
        tick();
        chk("held_addr3", s_addr, 32'hbfc0_0004);
        aok_p = 100;
        tick();
        chk("held_accept", s_addr, 32'hbfc0_0004);
        tick();
        chk("new_stream_valid", 32'(s_v), 32'd1);
        chk("new_stream_addr", s_addr, 32'h8000_2000);
        repeat (6) tick();
        // redirect coinciding with data_ok and a pop
        chk("steady_dok", 32'(s_dok), 32'd1);
        redir_v = 1'b1; redir_pc = 32'h8000_3000;
        tick();
        chk("same_cycle_dok", 32'(s_dok), 32'd1);
        chk("same_cycle_ov", 32'(s_ov), 32'd1);
        tick();
        chk("same_cycle_flush", 32'(s_ov), 32'd0);
        repeat (6) tick();
        // address wrap past fffffffc
        redir_v = 1'b1; redir_pc = 32'hffff_fff8;
        tick();
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            tick();
            if (s_pop && s_pc == 32'h0) found = 1;
        end
        chk("wrap_to_zero", 32'(found), 32'd1);
        // random traffic with a mid-stream reset
        aok_p = 60; dok_p = 60; rdy_p = 70; lat_max = 2; redir_p = 20;
        repeat (1500) tick();
        do_reset();
        repeat (1500) tick();
        // drain: forward progress once the bus and decode are both free
        aok_p = 100; dok_p = 100; rdy_p = 100; lat_max = 0; redir_p = 0;
        pops = 0;
        repeat (40) begin
            tick();
            pops += int'(s_pop);
        end
        chk("drain_progress", 32'(pops >= 30), 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
